pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's 8-bit PWM generator. Measures an incoming PWM waveform and recovers its 8-bit duty value, so it is directly comparable to the generator's pwmValue.
- Generator frame: 255 clocks; output high for pwmValue clocks; 0 = always low, 255 = always high.
- Used for loopback self-test and for reading external PWM sources in the same clock domain.

Parameters:
- PERIOD, 255, expected frame length in clocks; a mismatch sets periodErr.
- CNT_W, 10, width of the period/high counters; must satisfy 2^CNT_W-1 >= TIMEOUT.
- TIMEOUT, 510, clocks without a rising edge before a static level is reported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable; low freezes capture.
- pwmIn  input  1  PWM input; may be asynchronous to clk.
- dutyValue  output  8  last measured high time, saturated to 255.
- periodValue  output  CNT_W  last measured rise-to-rise period in clocks.
- valid  output  1  one-cycle strobe: dutyValue/periodValue just updated.
- locked  output  1  at least one full edge-to-edge frame measured since reset/enable.
- periodErr  output  1  last frame period != PERIOD (sticky until next update).

Behaviour:
- Reset (rst_n=0, async): dutyValue=0, periodValue=0, valid=0, locked=0, periodErr=0. Sync flops cleared, counters 0, state=IDLE.
- Input path: 2-flop synchronizer to s, plus prev register. rise = s & ~prev. Input-to-rise latency is 3 clk.
- States:
  - IDLE: counters 0; on rise go to MEASURE with perCnt=1, highCnt=1.
  - MEASURE: each non-rise cycle perCnt+=1 and highCnt+=s.
- On rise in MEASURE, registered on the next edge:
  - dutyValue = (highCnt>255) ? 255 : highCnt[7:0]
  - periodValue = perCnt
  - periodErr = (perCnt != PERIOD)
  - locked = 1; valid = 1 for one cycle
  - Counters restart at perCnt=1, highCnt=1.
- Timeout: if perCnt reaches TIMEOUT in MEASURE or IDLE with no rise:
  - dutyValue = s ? 255 : 0; periodValue = 0; periodErr = 0; valid = 1 for one cycle; locked unchanged.
  - perCnt resets to 0 and counting continues, so valid re-strobes every TIMEOUT clocks while the input is static.
  - State moves to IDLE, so the first rise after a static period starts a fresh frame and does not publish a stale measurement.
- IDLE also counts perCnt, for timeout only.
- Rise and timeout in the same cycle: rise wins; no timeout strobe.
- Counters never wrap, because TIMEOUT bounds them; highCnt saturation in dutyValue covers long-high inputs with PERIOD<TIMEOUT.
- enable=0: state → IDLE, counters 0, valid=0, locked=0. dutyValue/periodValue/periodErr hold. The synchronizer keeps running.
- enable rising: same as leaving reset, except outputs hold until the first update.
- Reset mid-frame: immediate return to reset values; no partial frame is published.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined: a 3-sample majority/stability glitch filter sits after the synchronizer. s changes only after 3 consecutive identical synchronized samples, so input-to-rise latency becomes 5 clk and pulses of 1–2 clk are ignored.
- Not defined: s is the raw synchronizer output; 1-clk pulses are measured.

Test Plan:
- Loopback from the PWM generator, pwmValue=100 → after 2 frames, valid pulses every 255 clk; dutyValue=100, periodValue=255, periodErr=0, locked=1.
- Sweep pwmValue 1, 128, 254 → dutyValue 1, 128, 254 within 2 frames of each change; periodErr stays 0.
- pwmIn held 0, then held 1 → valid at 510 clk after the last rise with dutyValue=0, repeating every 510 clk; then dutyValue=255 when held high.
- External PWM with period 200, high 50 → dutyValue=50, periodValue=200, periodErr=1.
- Assert rst_n low mid-frame, then release, then drive pwmValue=30 → outputs 0 immediately; first valid only after 2 rises; dutyValue=30.
- With PWM_CAPTURE_FILTER_EN, inject a 2-clk glitch high inside the low phase of pwmValue=100 → dutyValue=100, periodValue=255. Without the macro, periodValue is shortened → periodErr=1.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: receive-side counterpart of the 8-bit PWM generator.
// It measures the rise-to-rise period and the high time of pwmIn, and publishes
// the duty saturated to 8 bits so the result is directly comparable to pwmValue.
// Optional feature macro: PWM_CAPTURE_FILTER_EN adds a 3-sample stability
// filter after the synchronizer, so pulses of 1-2 clocks are ignored.
module pwm_capture #(
    parameter int unsigned PERIOD  = 255,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned TIMEOUT = 510
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwmIn,
    output logic [7:0]       dutyValue,
    output logic [CNT_W-1:0] periodValue,
    output logic             valid,
    output logic             locked,
    output logic             periodErr
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] LP_PERIOD   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_DUTY_MAX = CNT_W'(255);

    // input path
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_s;
    logic             w_rise;

    // measurement state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] w_high_nxt;

    // published results
    logic [7:0]       r_duty;
    logic [7:0]       w_duty_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             r_err;
    logic             w_err_nxt;

    // two-flop synchronizer for the possibly asynchronous PWM input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwmIn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] r_hist;

    // two older synchronized samples kept for the stability check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    // accept a new level only after three identical samples; r_prev holds the
    // last accepted level, so it doubles as the filter's hold register
    always_comb begin
        w_s = r_prev;
        if ((r_sync2 == r_hist[0]) && (r_hist[0] == r_hist[1])) begin
            w_s = r_sync2;
        end
    end
`else
    assign w_s = r_sync2;
`endif

    // previous conditioned level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_rise = w_s & ~r_prev;

    // state, counters and published results register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_per    <= '0;
            r_high   <= '0;
            r_duty   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_per    <= w_per_nxt;
            r_high   <= w_high_nxt;
            r_duty   <= w_duty_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_locked <= w_locked_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // next-state: a rise closes a frame (published only from MEASURE); with no
    // rise, reaching TIMEOUT-1 reports the static level and falls back to IDLE
    always_comb begin
        w_state_nxt  = r_state;
        w_per_nxt    = r_per;
        w_high_nxt   = r_high;
        w_duty_nxt   = r_duty;
        w_period_nxt = r_period;
        w_valid_nxt  = 1'b0;
        w_locked_nxt = r_locked;
        w_err_nxt    = r_err;

        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_per_nxt    = '0;
            w_high_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else if (w_rise) begin
            if (r_state == ST_MEASURE) begin
                w_duty_nxt   = (r_high > LP_DUTY_MAX) ? 8'hFF : r_high[7:0];
                w_period_nxt = r_per;
                w_err_nxt    = (r_per != LP_PERIOD);
                w_locked_nxt = 1'b1;
                w_valid_nxt  = 1'b1;
            end
            w_state_nxt = ST_MEASURE;
            w_per_nxt   = CNT_W'(1);
            w_high_nxt  = CNT_W'(1);
        end else if (r_per == LP_TO_LAST) begin
            w_duty_nxt   = w_s ? 8'hFF : 8'h00;
            w_period_nxt = '0;
            w_err_nxt    = 1'b0;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = ST_IDLE;
            w_per_nxt    = '0;
            w_high_nxt   = '0;
        end else begin
            w_per_nxt = r_per + CNT_W'(1);
            if (r_state == ST_MEASURE) begin
                w_high_nxt = r_high + CNT_W'(w_s);
            end
        end
    end

    assign dutyValue   = r_duty;
    assign periodValue = r_period;
    assign valid       = r_valid;
    assign locked      = r_locked;
    assign periodErr   = r_err;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms (directed and $urandom) into pwm_capture
// and compares every strobe against a timestamp-based reference model.
module tb_pwm_capture;

    localparam int unsigned PERIOD  = 255;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned TIMEOUT = 510;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pwmIn;
    logic [7:0]       dutyValue;
    logic [CNT_W-1:0] periodValue;
    logic             valid;
    logic             locked;
    logic             periodErr;

    always #5 clk = ~clk;

    pwm_capture #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pwmIn      (pwmIn),
        .dutyValue  (dutyValue),
        .periodValue(periodValue),
        .valid      (valid),
        .locked     (locked),
        .periodErr  (periodErr)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: h[k] is the pwmIn value driven k posedges ago
    bit h[5];
    bit m_prev;
    int m_t;
    bit m_armed;
    int m_last_rise;
    int m_anchor;
    int m_hi;
    bit exp_valid;
    int exp_duty;
    int exp_period;
    bit exp_err;
    bit exp_locked;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) h[i] = 1'b0;
        m_prev     = 1'b0;
        m_armed    = 1'b0;
        m_hi       = 0;
        m_anchor   = m_t;
        exp_valid  = 1'b0;
        exp_duty   = 0;
        exp_period = 0;
        exp_err    = 1'b0;
        exp_locked = 1'b0;
    endtask

    // frames are delimited by rises of the conditioned input; the high count is
    // the number of high samples from one rise up to the next; a timeout fires
    // TIMEOUT-1 cycles after the last rise, timeout or (re)start
    task automatic model_step();
        bit s;
        bit rise;
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0] = pwmIn;
`ifdef PWM_CAPTURE_FILTER_EN
        s = ((h[2] == h[3]) && (h[3] == h[4])) ? h[2] : m_prev;
`else
        s = h[2];
`endif
        rise      = s && !m_prev;
        exp_valid = 1'b0;
        if (!enable) begin
            m_armed    = 1'b0;
            m_hi       = 0;
            m_anchor   = m_t + 1;
            exp_locked = 1'b0;
        end else if (rise) begin
            if (m_armed) begin
                exp_duty   = (m_hi > 255) ? 255 : m_hi;
                exp_period = m_t - m_last_rise;
                exp_err    = (exp_period != int'(PERIOD));
                exp_locked = 1'b1;
                exp_valid  = 1'b1;
            end
            m_armed     = 1'b1;
            m_last_rise = m_t;
            m_anchor    = m_t;
            m_hi        = 1;
        end else if (m_t - m_anchor == int'(TIMEOUT) - 1) begin
            exp_duty   = s ? 255 : 0;
            exp_period = 0;
            exp_err    = 1'b0;
            exp_valid  = 1'b1;
            m_armed    = 1'b0;
            m_hi       = 0;
            m_anchor   = m_t + 1;
        end else if (m_armed) begin
            m_hi += int'(s);
        end
        m_prev = s;
        m_t++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  32'(valid),       32'(exp_valid));
        check({tag, ".duty"},   32'(dutyValue),   32'(exp_duty));
        check({tag, ".period"}, 32'(periodValue), 32'(exp_period));
        check({tag, ".err"},    32'(periodErr),   32'(exp_err));
        check({tag, ".locked"}, 32'(locked),      32'(exp_locked));
    endtask

    // one clock: drive the input, advance the model, compare after the edge
    task automatic cyc(input bit b);
        pwmIn = b;
        model_step();
        @(negedge clk);
        check("valid", 32'(valid), 32'(exp_valid));
        if (exp_valid || valid) begin
            check("duty",   32'(dutyValue),   32'(exp_duty));
            check("period", 32'(periodValue), 32'(exp_period));
            check("err",    32'(periodErr),   32'(exp_err));
            check("locked", 32'(locked),      32'(exp_locked));
        end
    endtask

    task automatic frames(input int unsigned per, input int unsigned high, input int unsigned n);
        repeat (n) begin
            for (int unsigned i = 0; i < per; i++) cyc(i < high);
        end
    endtask

    task automatic hold_level(input bit lvl, input int unsigned n);
        repeat (n) cyc(lvl);
    endtask

    task automatic glitch_frames(input int unsigned n);
        repeat (n) begin
            for (int unsigned i = 0; i < 255; i++) cyc((i < 100) || (i == 170) || (i == 171));
        end
    endtask

    task automatic do_reset(input int unsigned n);
        rst_n = 1'b0;
        pwmIn = 1'b0;
        #1;
        check("rst.duty",   32'(dutyValue),   32'd0);
        check("rst.period", 32'(periodValue), 32'd0);
        check("rst.valid",  32'(valid),       32'd0);
        check("rst.locked", 32'(locked),      32'd0);
        check("rst.err",    32'(periodErr),   32'd0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned per;
        int unsigned high;
        m_t    = 0;
        rst_n  = 1'b0;
        enable = 1'b1;
        pwmIn  = 1'b0;
        repeat (2) @(negedge clk);
        do_reset(3);

        // loopback-style frames, then duty sweep including saturation-free edges
        frames(255, 100, 4);
        check_all("pwm100");
        frames(255, 1, 3);
        frames(255, 128, 3);
        frames(255, 254, 3);
        check_all("sweep");

        // static levels: timeouts every TIMEOUT clocks
        hold_level(1'b0, 1200);
        check_all("static0");
        frames(255, 60, 2);
        hold_level(1'b1, 1200);
        check_all("static1");

        // foreign period and long-high saturation
        frames(200, 50, 4);
        check_all("per200");
        frames(400, 300, 3);
        check_all("sat");

        // reset in the middle of a frame
        frames(255, 30, 1);
        for (int unsigned i = 0; i < 120; i++) cyc(i < 30);
        do_reset(4);
        frames(255, 30, 4);
        check_all("post_rst");

        // short glitch in the low phase
        glitch_frames(4);
        check_all("glitch");

        // enable drop freezes results and clears locked
        enable = 1'b0;
        hold_level(1'b1, 5);
        check_all("dis");
        enable = 1'b1;
        frames(255, 77, 3);
        check_all("reen");

        // randomized periods, duties and enable drops
        for (int k = 0; k < 24; k++) begin
            per  = $urandom_range(600, 2);
            high = $urandom_range(per, 0);
            if ($urandom_range(3, 0) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(20, 1)) cyc(1'($urandom_range(1, 0)));
                enable = 1'b1;
            end
            frames(per, high, $urandom_range(3, 2));
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
